// File: rtl/mb_rtu_resp_ctrl.sv
// mb_rtu_resp_ctrl: Modbus RTU slave reply sequencer.
// Validates a parsed request, reads registers and streams the CRC16 reply to uart_tx.
module mb_rtu_resp_ctrl #(
  parameter logic [7:0] SLAVE_ADDR  = 8'h01,
  parameter int         REG_DEPTH   = 256,
  parameter int         MAX_REGS    = 125,
  parameter int         TURN_CYCLES = 100000,
  parameter int         TX_TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [7:0]  req_func,
  input  logic [15:0] req_reg,
  input  logic [15:0] req_num,
  input  logic        req_crc_err,
  output logic        reg_rd_en,
  output logic [15:0] reg_rd_addr,
  input  logic [15:0] reg_rd_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        req_drop,
  output logic        tx_abort
);

  localparam int CMAX = (TURN_CYCLES > TX_TIMEOUT) ? TURN_CYCLES : TX_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TX_TIMEOUT - 1);
  localparam logic [16:0]   MAX_N     = 17'(MAX_REGS);
  localparam logic [16:0]   DEPTH_N   = 17'(REG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_TURN, S_HDR, S_RD, S_DHI, S_DLO, S_CRCL, S_CRCH
  } state_e;

  state_e        state_q, state_d;
  logic          wait_q, wait_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    hidx_q, hidx_d;
  logic [15:0]   idx_q, idx_d;
  logic [7:0]    func_q, func_d;
  logic [15:0]   reg_q, reg_d;
  logic [15:0]   num_q, num_d;
  logic [7:0]    code_q, code_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   crc_q, crc_d;
  logic          drop_q, drop_d;

  logic [16:0] end_sum;
  logic [7:0]  code_acc;
  logic        exc, f03, byte_st;
  logic [2:0]  hdr_last;
  logic [7:0]  hb;

  function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                          input logic [7:0]  b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Unknown function wins over range checks; count is checked before address.
  assign end_sum = {1'b0, req_reg} + {1'b0, req_num};
  always_comb begin
    code_acc = 8'h00;
    if (req_func != 8'h03 && req_func != 8'h10)
      code_acc = 8'h01;
    else if (req_num == '0 || {1'b0, req_num} > MAX_N)
      code_acc = 8'h03;
    else if (end_sum > DEPTH_N)
      code_acc = 8'h02;
  end

  assign exc      = (code_q != 8'h00);
  assign f03      = (func_q == 8'h03);
  assign hdr_last = (exc || f03) ? 3'd2 : 3'd5;
  assign byte_st  = (state_q == S_HDR) || (state_q == S_DHI) ||
                    (state_q == S_DLO) || (state_q == S_CRCL) ||
                    (state_q == S_CRCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
      hidx_q  <= '0;
      idx_q   <= '0;
      func_q  <= '0;
      reg_q   <= '0;
      num_q   <= '0;
      code_q  <= '0;
      data_q  <= '0;
      crc_q   <= 16'hFFFF;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      hidx_q  <= hidx_d;
      idx_q   <= idx_d;
      func_q  <= func_d;
      reg_q   <= reg_d;
      num_q   <= num_d;
      code_q  <= code_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    hidx_d  = hidx_q;
    idx_d   = idx_q;
    func_d  = func_q;
    reg_d   = reg_q;
    num_d   = num_q;
    code_d  = code_q;
    data_d  = data_q;
    crc_d   = crc_q;
    drop_d  = req_valid && (state_q != S_IDLE || req_crc_err);
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !req_crc_err) begin
          state_d = S_TURN;
          func_d  = req_func;
          reg_d   = req_reg;
          num_d   = req_num;
          code_d  = code_acc;
          crc_d   = 16'hFFFF;
          cnt_d   = '0;
          hidx_d  = '0;
          idx_d   = '0;
          wait_d  = 1'b0;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          data_d  = reg_rd_data;
          wait_d  = 1'b0;
          state_d = S_DHI;
        end
      end
      default: begin
        if (!wait_q) begin
          wait_d = 1'b1;
          cnt_d  = '0;
          if (state_q == S_HDR || state_q == S_DHI || state_q == S_DLO)
            crc_d = crc_upd(crc_q, tx_data);
        end else if (tx_done) begin
          wait_d = 1'b0;
          cnt_d  = '0;
          unique case (state_q)
            S_HDR: begin
              if (hidx_q == hdr_last) begin
                hidx_d  = '0;
                state_d = (f03 && !exc) ? S_RD : S_CRCL;
              end else begin
                hidx_d = hidx_q + 3'd1;
              end
            end
            S_DHI: state_d = S_DLO;
            S_DLO: begin
              idx_d   = idx_q + 16'd1;
              state_d = (idx_q + 16'd1 == num_q) ? S_CRCL : S_RD;
            end
            S_CRCL: state_d = S_CRCH;
            default: state_d = S_IDLE;
          endcase
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          wait_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    case (hidx_q)
      3'd0:    hb = SLAVE_ADDR;
      3'd1:    hb = exc ? (func_q | 8'h80) : func_q;
      3'd2:    hb = exc ? code_q : (f03 ? {num_q[6:0], 1'b0} : reg_q[15:8]);
      3'd3:    hb = reg_q[7:0];
      3'd4:    hb = num_q[15:8];
      default: hb = num_q[7:0];
    endcase
  end

  always_comb begin
    tx_data     = 8'h00;
    reg_rd_en   = 1'b0;
    reg_rd_addr = 16'h0000;
    unique case (state_q)
      S_HDR:  tx_data = hb;
      S_DHI:  tx_data = data_q[15:8];
      S_DLO:  tx_data = data_q[7:0];
      S_CRCL: tx_data = crc_q[7:0];
      S_CRCH: tx_data = crc_q[15:8];
      S_RD: begin
        reg_rd_en   = !wait_q;
        reg_rd_addr = !wait_q ? (reg_q + idx_q) : 16'h0000;
      end
      default: ;
    endcase
    tx_start = byte_st && !wait_q;
    tx_abort = byte_st && wait_q && !tx_done && (cnt_q == TMO_LAST);
    busy     = (state_q != S_IDLE);
    req_drop = drop_q;
  end

endmodule

// File: tb/tb_mb_rtu_resp_ctrl.sv
// tb_mb_rtu_resp_ctrl: directed + random requests against a frame-level model.
// Models uart_tx handshake and a registered holding-register file.
module tb_mb_rtu_resp_ctrl;
  localparam int TURN = 20;
  localparam int TMO  = 200;
  localparam logic [7:0] ADDR = 8'h11;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_func = '0;
  logic [15:0] req_reg = '0;
  logic [15:0] req_num = '0;
  logic        req_crc_err = 1'b0;
  logic        reg_rd_en;
  logic [15:0] reg_rd_addr;
  logic [15:0] reg_rd_data = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        req_drop;
  logic        tx_abort;

  int total = 0;
  int passed = 0;
  bq_t got;
  logic [15:0] rdq[$];
  logic [15:0] mem [256];
  int pend = 0;
  int hold_at = -1;
  int viol = 0;
  int drops = 0;
  int aborts = 0;

  mb_rtu_resp_ctrl #(
    .SLAVE_ADDR(ADDR), .REG_DEPTH(256), .MAX_REGS(125),
    .TURN_CYCLES(TURN), .TX_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_func(req_func),
    .req_reg(req_reg), .req_num(req_num),
    .req_crc_err(req_crc_err),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .req_drop(req_drop), .tx_abort(tx_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && reg_rd_en) begin
      rdq.push_back(reg_rd_addr);
      reg_rd_data <= mem[reg_rd_addr[7:0]];
    end
  end

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (req_drop) drops++;
    if (tx_abort) aborts++;
    if (!rst_n) begin
      pend = 0;
    end else if (pend > 0) begin
      if (tx_start) viol++;
      pend--;
      if (pend == 0) tx_done = 1'b1;
    end else if (tx_start) begin
      got.push_back(tx_data);
      if (got.size() != hold_at) pend = $urandom_range(1, 4);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] crc16(input bq_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t model(input logic [7:0] f, input logic [15:0] r,
                                input logic [15:0] n);
    bq_t q;
    logic [7:0]  code;
    logic [15:0] c;
    logic [15:0] w;
    code = 8'h00;
    if (f != 8'h03 && f != 8'h10) code = 8'h01;
    else if (n == 0 || n > 125) code = 8'h03;
    else if (int'(r) + int'(n) > 256) code = 8'h02;
    q.push_back(ADDR);
    if (code != 0) begin
      q.push_back(f | 8'h80);
      q.push_back(code);
    end else if (f == 8'h03) begin
      q.push_back(f);
      q.push_back(8'(2 * n));
      for (int i = 0; i < int'(n); i++) begin
        w = mem[int'(r) + i];
        q.push_back(w[15:8]);
        q.push_back(w[7:0]);
      end
    end else begin
      q.push_back(f);
      q.push_back(r[15:8]);
      q.push_back(r[7:0]);
      q.push_back(n[15:8]);
      q.push_back(n[7:0]);
    end
    c = crc16(q);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    return q;
  endfunction

  task automatic send_req(input logic [7:0] f, input logic [15:0] r,
                          input logic [15:0] n, input logic e,
                          input bit clr);
    @(negedge clk);
    if (clr) begin
      got.delete();
      rdq.delete();
    end
    req_valid   = 1'b1;
    req_func    = f;
    req_reg     = r;
    req_num     = n;
    req_crc_err = e;
    @(negedge clk);
    req_valid   = 1'b0;
    req_crc_err = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 4000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input bq_t exp);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic check_reads(input string tag, input logic [7:0] f,
                             input logic [15:0] r, input logic [15:0] n,
                             input bq_t exp);
    int cnt;
    cnt = (f == 8'h03 && exp[1] == 8'h03) ? int'(n) : 0;
    check({tag, "_nrd"}, rdq.size(), cnt);
    for (int i = 0; i < cnt && i < rdq.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rdq[i], r + 16'(i));
  endtask

  task automatic txn(input string tag, input logic [7:0] f,
                     input logic [15:0] r, input logic [15:0] n);
    bq_t exp;
    exp = model(f, r, n);
    send_req(f, r, n, 1'b0, 1'b1);
    wait_idle(tag);
    check_frame(tag, exp);
    check_reads(tag, f, r, n, exp);
  endtask

  initial begin
    bq_t k;
    bq_t exp;
    int d0;
    int a0;
    int n;
    logic [7:0]  f;
    logic [15:0] r;
    logic [15:0] num;

    foreach (mem[i]) mem[i] = 16'($urandom);
    mem[8'h6B] = 16'hAE41;
    mem[8'h6C] = 16'h5652;
    mem[8'h6D] = 16'h4340;

    repeat (3) @(negedge clk);
    check("reset_outs", {busy, tx_start, reg_rd_en, req_drop, tx_abort,
                         tx_data, reg_rd_addr}, 0);
    #2 rst_n = 1'b1;

    txn("rd3", 8'h03, 16'h006B, 16'd3);
    k = '{8'h11, 8'h03, 8'h06, 8'hAE, 8'h41, 8'h56, 8'h52,
          8'h43, 8'h40, 8'h49, 8'hAD};
    check_frame("rd3_vec", k);

    txn("wr2", 8'h10, 16'h0001, 16'd2);
    txn("exc_addr", 8'h03, 16'h00FF, 16'd2);
    check("exc_addr_code", got[2], 8'h02);
    txn("exc_num0", 8'h03, 16'h0010, 16'd0);
    check("exc_num0_code", got[2], 8'h03);
    txn("exc_num126", 8'h10, 16'h0000, 16'd126);
    txn("max125", 8'h03, 16'h0000, 16'd125);
    txn("edge_fe", 8'h03, 16'h00FE, 16'd2);
    txn("bad_func", 8'h05, 16'h0000, 16'd1);

    d0 = drops;
    send_req(8'h03, 16'h0000, 16'd1, 1'b1, 1'b1);
    repeat (TURN + 10) @(negedge clk);
    check("crc_drop", drops - d0, 1);
    check("crc_notx", got.size(), 0);
    check("crc_busy", busy, 0);

    exp = model(8'h03, 16'h0020, 16'd4);
    d0 = drops;
    send_req(8'h03, 16'h0020, 16'd4, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    send_req(8'h10, 16'h0005, 16'd5, 1'b0, 1'b0);
    wait_idle("busy_drop");
    check_frame("busy_drop", exp);
    check("busy_drop_cnt", drops - d0, 1);

    hold_at = 2;
    a0 = aborts;
    send_req(8'h03, 16'h006B, 16'd3, 1'b0, 1'b1);
    n = 0;
    while (aborts == a0 && n < TURN + TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_seen", aborts - a0, 1);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_bytes", got.size(), 2);
    hold_at = -1;
    txn("after_abort", 8'h03, 16'h006B, 16'd3);

    send_req(8'h03, 16'h006B, 16'd3, 1'b0, 1'b1);
    n = 0;
    while (got.size() < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_dlo", got.size(), 5);
    #2 rst_n = 1'b0;
    #1 check("rst_outs", {busy, tx_start, reg_rd_en, req_drop, tx_abort,
                          tx_data, reg_rd_addr}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    txn("after_rst", 8'h03, 16'h006B, 16'd3);

    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 9);
      f = (n < 4) ? 8'h03 : (n < 7) ? 8'h10 : 8'($urandom);
      r = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255))
                                      : 16'($urandom_range(200, 260));
      num = 16'($urandom_range(0, 130));
      txn($sformatf("rnd%0d", t), f, r, num);
    end

    check("no_double_start", viol, 0);
    check("abort_total", aborts, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
